// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider / enable generator.
package clk_div_pkg;

   localparam int DEF_DIV_W       = 16;
   localparam int DEF_DIV_INIT    = 27;
   localparam int DEF_LOCK_CYCLES = 1024;

   // A single channel still needs a one-bit index port.
   function automatic int ch_idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: pending/active divisor, period counter, ce strobe and
// 50%-duty divided clock, all registered on the single input clock.
module clk_div_chan import clk_div_pkg::*; #(
   parameter int DIV_W    = DEF_DIV_W,
   parameter int DIV_INIT = DEF_DIV_INIT
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_run,
   input  logic             i_sync,
   input  logic             i_wr,
   input  logic [DIV_W-1:0] i_wr_div,
   output logic             o_ce,
   output logic             o_clk
);

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_act;
   logic [DIV_W-1:0] r_pend;
   logic             r_ce;
   logic             r_clk;

   logic [DIV_W-1:0] w_pend_nxt;
   logic             w_tc;

   // A write in the same cycle bypasses the pending register wherever it is loaded.
   assign w_pend_nxt = i_wr ? i_wr_div : r_pend;
   assign w_tc       = (r_cnt == r_act - DIV_W'(1));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt  <= '0;
         r_act  <= DIV_W'(DIV_INIT);
         r_pend <= DIV_W'(DIV_INIT);
         r_ce   <= 1'b0;
         r_clk  <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
         if (i_sync) begin
            r_act <= w_pend_nxt;
            r_cnt <= '0;
            r_ce  <= 1'b0;
            r_clk <= 1'b0;
         end else if (!i_run || r_act == '0) begin
            // Disabled channels pick up a new divisor immediately and restart from zero.
            if (r_act == '0) begin
               r_act <= w_pend_nxt;
            end
            r_cnt <= '0;
            r_ce  <= 1'b0;
            r_clk <= 1'b0;
         end else if (w_tc) begin
            r_act <= w_pend_nxt;
            r_cnt <= '0;
            r_ce  <= 1'b1;
            // Switching to disabled parks the output low rather than leaving a stray high.
            r_clk <= (w_pend_nxt == '0) ? 1'b0 : ~r_clk;
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
            r_ce  <= 1'b0;
         end
      end
   end

   assign o_ce  = r_ce;
   assign o_clk = r_clk;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider: lock sequencing after reset, divisor write decode,
// and sync fan-out to NUM_CH independent divider channels.
module clk_div_gen import clk_div_pkg::*; #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DIV_INIT    = DEF_DIV_INIT,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input  logic                        clkin,
   input  logic                        reset,
   input  logic                        wr_en,
   input  logic [ch_idx_w(NUM_CH)-1:0] wr_ch,
   input  logic [DIV_W-1:0]            wr_div,
   input  logic                        sync,
   output logic                        lock,
   output logic [NUM_CH-1:0]           ce,
   output logic [NUM_CH-1:0]           clkout
);

   localparam int CH_W = ch_idx_w(NUM_CH);
   localparam int LCW  = $clog2(LOCK_CYCLES + 1);

   logic [LCW-1:0]    r_lock_cnt;
   logic              r_lock;
   logic [NUM_CH-1:0] w_wr;

   // The counter freezes once locked; lock is sticky until the next reset.
   always_ff @(posedge clkin) begin
      if (reset) begin
         r_lock_cnt <= '0;
         r_lock     <= 1'b0;
      end else if (!r_lock) begin
         r_lock_cnt <= r_lock_cnt + LCW'(1);
         if (r_lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
            r_lock <= 1'b1;
         end
      end
   end

   assign lock = r_lock;

   // Out-of-range channel indices match no decode term and are dropped.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_wr[g] = wr_en && (wr_ch == CH_W'(g));

      clk_div_chan #(
         .DIV_W    (DIV_W),
         .DIV_INIT (DIV_INIT)
      ) u_chan (
         .i_clk    (clkin),
         .i_reset  (reset),
         .i_run    (r_lock),
         .i_sync   (sync),
         .i_wr     (w_wr[g]),
         .i_wr_div (wr_div),
         .o_ce     (ce[g]),
         .o_clk    (clkout[g])
      );
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: reset/lock table, directed divisor/sync/reset sequences,
// then random stimulus, all compared every cycle against a time-based reference model.
module tb_clk_div_gen;

   localparam int NCH   = 5;
   localparam int DW    = 8;
   localparam int DINIT = 3;
   localparam int LC    = 16;
   localparam int CW    = 3;

   logic          clkin = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [CW-1:0] wr_ch;
   logic [DW-1:0] wr_div;
   logic          sync;
   logic          lock;
   logic [NCH-1:0] ce;
   logic [NCH-1:0] clkout;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: each channel remembers the edge its current period began;
   // a strobe is due when exactly D edges have elapsed since then.
   int m_act   [NCH];
   int m_pend  [NCH];
   int m_start [NCH];
   bit m_ce    [NCH];
   bit m_clk   [NCH];
   int m_since = 0;
   bit m_lock  = 1'b0;

   typedef struct {
      int cyc;
      bit lock;
      bit ce0;
      bit clk0;
   } vec_t;

   vec_t tbl[10];

   always #5 clkin = ~clkin;

   clk_div_gen #(
      .NUM_CH      (NCH),
      .DIV_W       (DW),
      .DIV_INIT    (DINIT),
      .LOCK_CYCLES (LC)
   ) dut (
      .clkin  (clkin),
      .reset  (reset),
      .wr_en  (wr_en),
      .wr_ch  (wr_ch),
      .wr_div (wr_div),
      .sync   (sync),
      .lock   (lock),
      .ce     (ce),
      .clkout (clkout)
   );

   function automatic vec_t mk(input int c, input bit l, input bit e, input bit k);
      vec_t v;
      v.cyc = c; v.lock = l; v.ce0 = e; v.clk0 = k;
      return v;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_edge();
      bit lk;
      int pn;
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_act[c] = DINIT; m_pend[c] = DINIT; m_start[c] = cyc;
            m_ce[c] = 1'b0; m_clk[c] = 1'b0;
         end
         m_since = 0;
         m_lock  = 1'b0;
      end else begin
         lk = m_lock;
         for (int c = 0; c < NCH; c++) begin
            pn = (wr_en && int'(wr_ch) == c) ? int'(wr_div) : m_pend[c];
            m_pend[c] = pn;
            if (sync) begin
               m_act[c] = pn; m_start[c] = cyc; m_ce[c] = 1'b0; m_clk[c] = 1'b0;
            end else if (!lk || m_act[c] == 0) begin
               if (m_act[c] == 0) m_act[c] = pn;
               m_start[c] = cyc; m_ce[c] = 1'b0; m_clk[c] = 1'b0;
            end else if (cyc - m_start[c] == m_act[c]) begin
               m_ce[c]    = 1'b1;
               m_clk[c]   = (pn == 0) ? 1'b0 : !m_clk[c];
               m_act[c]   = pn;
               m_start[c] = cyc;
            end else begin
               m_ce[c] = 1'b0;
            end
         end
         m_since++;
         m_lock = (m_since >= LC);
      end
   endtask

   task automatic tick();
      logic [NCH-1:0] ev;
      logic [NCH-1:0] ec;
      @(posedge clkin);
      cyc++;
      model_edge();
      #1;
      for (int c = 0; c < NCH; c++) begin
         ev[c] = m_ce[c];
         ec[c] = m_clk[c];
      end
      chk("model_lock", int'(lock), int'(m_lock));
      chk("model_ce", int'(ce), int'(ev));
      chk("model_clkout", int'(clkout), int'(ec));
   endtask

   task automatic do_write(input int ch, input int val);
      wr_en  = 1'b1;
      wr_ch  = CW'(ch);
      wr_div = DW'(val);
      tick();
      wr_en  = 1'b0;
   endtask

   task automatic next_ce(input int ch, output int t);
      t = -1;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (ce[ch]) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) chk($sformatf("timeout_ce%0d", ch), 0, 1);
   endtask

   initial begin
      int rel, t0, t1, t2, t3, s, n;
      logic prev;

      tbl[0] = mk(1,  1'b0, 1'b0, 1'b0);
      tbl[1] = mk(15, 1'b0, 1'b0, 1'b0);
      tbl[2] = mk(16, 1'b1, 1'b0, 1'b0);
      tbl[3] = mk(18, 1'b1, 1'b0, 1'b0);
      tbl[4] = mk(19, 1'b1, 1'b1, 1'b1);
      tbl[5] = mk(20, 1'b1, 1'b0, 1'b1);
      tbl[6] = mk(21, 1'b1, 1'b0, 1'b1);
      tbl[7] = mk(22, 1'b1, 1'b1, 1'b0);
      tbl[8] = mk(25, 1'b1, 1'b1, 1'b1);
      tbl[9] = mk(28, 1'b1, 1'b1, 1'b0);

      reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync = 1'b0;
      repeat (3) tick();
      chk("rst_lock", int'(lock), 0);
      chk("rst_ce", int'(ce), 0);
      chk("rst_clkout", int'(clkout), 0);

      // Lock sequence and first periods of channel 0 at the reset divisor.
      reset = 1'b0;
      rel   = 0;
      for (int i = 0; i < 10; i++) begin
         while (rel < tbl[i].cyc) begin
            tick();
            rel++;
         end
         chk($sformatf("tbl_lock_k%0d", tbl[i].cyc), int'(lock), int'(tbl[i].lock));
         chk($sformatf("tbl_ce0_k%0d", tbl[i].cyc), int'(ce[0]), int'(tbl[i].ce0));
         chk($sformatf("tbl_clk0_k%0d", tbl[i].cyc), int'(clkout[0]), int'(tbl[i].clk0));
      end

      // Mid-period write is deferred to the terminal count.
      next_ce(1, t0);
      tick();
      do_write(1, 5);
      next_ce(1, t1); chk("ch1_cur_period", t1 - t0, 3);
      next_ce(1, t2); chk("ch1_new_period_a", t2 - t1, 5);
      next_ce(1, t3); chk("ch1_new_period_b", t3 - t2, 5);
      do_write(1, 7);
      do_write(1, 9);
      next_ce(1, t0); chk("ch1_keep_5", t0 - t3, 5);
      next_ce(1, t1); chk("ch1_last_wins_9", t1 - t0, 9);

      // Divide-by-one: ce stuck high, clkout toggles every cycle.
      next_ce(2, t0);
      do_write(2, 1);
      next_ce(2, t1); chk("ch2_switch_at_tc", t1 - t0, 3);
      prev = clkout[2];
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("ch2_ce_high", int'(ce[2]), 1);
         chk("ch2_clk_toggle", int'(clkout[2]), int'(!prev));
         prev = clkout[2];
      end

      // Disable then re-enable channel 3.
      next_ce(3, t0);
      do_write(3, 0);
      next_ce(3, t1); chk("ch3_last_period", t1 - t0, 3);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ch3_off_ce", int'(ce[3]), 0);
         chk("ch3_off_clk", int'(clkout[3]), 0);
      end
      do_write(3, 4);
      t0 = cyc;
      next_ce(3, t1); chk("ch3_restart_delay", t1 - t0, 4);

      // Sync realigns channels of differing divisors.
      do_write(1, 4);
      repeat ($urandom_range(5, 15)) tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      s = cyc;
      chk("sync_ce_zero", int'(ce), 0);
      chk("sync_clk_zero", int'(clkout), 0);
      t0 = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ce[0] && ce[1]) begin
            t0 = cyc;
            break;
         end
      end
      chk("sync_coincide", t0 - s, 12);

      wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd5; sync = 1'b1;
      tick();
      wr_en = 1'b0; sync = 1'b0;
      s = cyc;
      next_ce(0, t0); chk("sync_write_bypass", t0 - s, 5);

      // Out-of-range channel writes leave every channel untouched.
      do_write(NCH, 1);
      do_write(7, 1);
      next_ce(0, t0);
      next_ce(0, t1); chk("bad_ch_ignored", t1 - t0, 5);

      // Reset mid-run discards the pending write and restarts lock.
      do_write(0, 2);
      reset = 1'b1;
      tick();
      chk("midrst_lock", int'(lock), 0);
      chk("midrst_ce", int'(ce), 0);
      chk("midrst_clkout", int'(clkout), 0);
      tick();
      reset = 1'b0;
      n = -1;
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (lock) begin
            n = i;
            break;
         end
      end
      chk("relock_cycles", n, LC);
      t0 = cyc;
      next_ce(0, t1); chk("relock_first_ce", t1 - t0, DINIT);
      next_ce(0, t2); chk("relock_period", t2 - t1, DINIT);

      // Random traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         wr_en  = ($urandom_range(0, 9) == 0);
         wr_ch  = CW'($urandom_range(0, 7));
         wr_div = DW'($urandom_range(0, 9));
         sync   = ($urandom_range(0, 49) == 0);
         reset  = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset = 1'b0; wr_en = 1'b0; sync = 1'b0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
